gravity_ctrl: RTL and testbench
===============================

// Module: gravity_ctrl
// PURPOSE
//  Sequential owner of the active brick's position. Applies timed gravity, soft drop, hard drop
//  and lock delay. Its registered pos feeds the drop-distance stage; the returned shift (free rows
//  below the brick) decides every step. Emits a lock request to the board-merge logic.
//  Position encoding: pos = {row, col[4:0]}; one row down = pos - 32.
// PARAMETERS
//  GRAV_PERIOD   50_000_000  cycles per gravity step, normal fall
//  SOFT_DIV      8           soft_drop divides GRAV_PERIOD by this value (integer, >=1)
//  LOCK_PERIOD   25_000_000  cycles a landed brick waits before lock request
// PORTS
//  clk        in   1             system clock
//  rst        in   1             asynchronous, active-high reset
//  spawn      in   1             pulse: load new brick at pos_in (accepted in IDLE only)
//  pos_in     in   `POS_LEN      spawn position
//  pos_set    in   1             pulse: move/rotate logic supplies pos_new (FALL/LANDED only)
//  pos_new    in   `POS_LEN      validated new position from move/rotate logic
//  soft_drop  in   1             level: fast gravity while high
//  hard_drop  in   1             pulse: drop by shift and lock immediately
//  shift      in   `BOARD_H      free rows below brick at current pos, value 0..19
//  pos        out  `POS_LEN      registered brick position
//  active     out  1             brick live (state FALL or LANDED)
//  lock_req   out  1             held high in LOCK_REQ until lock_ack
//  lock_ack   in   1             merge logic accepted lock
// BEHAVIOUR
//  Reset: state IDLE, pos=0, active=0, lock_req=0, gravity and lock counters 0.
//  States IDLE, FALL, LANDED, LOCK_REQ; all outputs registered, effect one cycle after input.
//  IDLE: spawn -> pos<=pos_in, grav_cnt<=0, FALL. Other inputs ignored.
//  FALL: grav_cnt counts to limit-1, limit = soft_drop ? GRAV_PERIOD/SOFT_DIV : GRAV_PERIOD
//   (limit floors to 1). At terminal count: shift!=0 -> pos<=pos-32, grav_cnt<=0;
//   shift==0 -> LANDED, lock_cnt<=0. Changing soft_drop mid-count: if grav_cnt >= new limit-1,
//   step fires next cycle.
//  LANDED: lock_cnt counts to LOCK_PERIOD-1 -> LOCK_REQ. pos_set that yields shift!=0
//   (sampled the cycle after pos updates) -> FALL, grav_cnt<=0. pos_set keeping shift==0 resets
//   lock_cnt (move reset).
//  Hard drop (FALL or LANDED): pos <= pos - (shift[4:0] << 5), mod 2^`POS_LEN; -> LOCK_REQ.
//   shift==0 -> pos unchanged, still LOCK_REQ. Bits shift[`BOARD_H-1:5] ignored.
//  pos_set (FALL or LANDED): pos<=pos_new; no bounds check here (move logic guarantees validity).
//  LOCK_REQ: lock_req=1, active=0, pos held; lock_ack -> IDLE, lock_req low next cycle.
//   spawn, pos_set, hard_drop ignored. lock_ack outside LOCK_REQ ignored.
//  Priority same cycle: hard_drop > pos_set > gravity step. Gravity terminal count coincident
//   with pos_set: grav_cnt holds at terminal, step applied next cycle using fresh shift.
//  spawn and lock_ack same cycle in LOCK_REQ: ack taken, spawn dropped (must be reissued).
//  rst mid-operation: immediate return to reset values; pending lock lost.
// CONFIGURATION
//  DROP_SCORE_EN defined: extra output drop_rows [7:0]; cleared on spawn accept; adds shift[4:0]
//   on hard drop; +1 per gravity step taken while soft_drop high; saturates at 255; reset 0.
//  DROP_SCORE_EN undefined: port and counter absent; all other behaviour identical.
// TESTING (bench params GRAV_PERIOD=4, SOFT_DIV=2, LOCK_PERIOD=3)
//  spawn pos_in=612 (row19,col4), shift=5 -> pos 580 after 4 cycles, 548 after 8; active=1.
//  shift forced 0 in FALL -> at next terminal count LANDED; 3 cycles later lock_req=1, pos held;
//   lock_ack -> IDLE, lock_req=0, active=0.
//  hard_drop with pos=612, shift=7 -> pos=388 next cycle, lock_req=1; drop_rows=7 if DROP_SCORE_EN.
//  soft_drop=1, shift=3 -> step every 2 cycles; drop_rows increments per step (DROP_SCORE_EN).
//  LANDED, pos_set pos_new=613 with shift->2 -> FALL, grav_cnt 0, step after 4 cycles.
//  hard_drop and pos_set same cycle -> pos_new ignored; rst asserted in LOCK_REQ -> pos=0,
//   lock_req=0 asynchronously.

Source files
------------

// File: rtl/gravity_ctrl_if.sv
// Command/status bundle between the active-brick position owner and its neighbours.
// drop_rows is present only when DROP_SCORE_EN is defined.
`ifndef POS_LEN
`define POS_LEN 10
`endif
`ifndef BOARD_H
`define BOARD_H 20
`endif

interface gravity_ctrl_if;
  logic                spawn;
  logic [`POS_LEN-1:0] pos_in;
  logic                pos_set;
  logic [`POS_LEN-1:0] pos_new;
  logic                soft_drop;
  logic                hard_drop;
  logic [`BOARD_H-1:0] shift;
  logic [`POS_LEN-1:0] pos;
  logic                active;
  logic                lock_req;
  logic                lock_ack;
`ifdef DROP_SCORE_EN
  logic [7:0]          drop_rows;

  modport master (output spawn, pos_in, pos_set, pos_new, soft_drop, hard_drop, shift, lock_ack,
                  input  pos, active, lock_req, drop_rows);
  modport slave  (input  spawn, pos_in, pos_set, pos_new, soft_drop, hard_drop, shift, lock_ack,
                  output pos, active, lock_req, drop_rows);
`else
  modport master (output spawn, pos_in, pos_set, pos_new, soft_drop, hard_drop, shift, lock_ack,
                  input  pos, active, lock_req);
  modport slave  (input  spawn, pos_in, pos_set, pos_new, soft_drop, hard_drop, shift, lock_ack,
                  output pos, active, lock_req);
`endif
endinterface

// File: rtl/gravity_ctrl.sv
// Owns the active brick position: timed/soft gravity, hard drop, lock delay and lock handshake.
// Optional DROP_SCORE_EN adds a saturating drop_rows counter on the interface.
`ifndef POS_LEN
`define POS_LEN 10
`endif
`ifndef BOARD_H
`define BOARD_H 20
`endif

module gravity_ctrl #(
  parameter int unsigned GRAV_PERIOD = 50_000_000,
  parameter int unsigned SOFT_DIV    = 8,
  parameter int unsigned LOCK_PERIOD = 25_000_000
) (
  input logic          clk,
  input logic          rst,
  gravity_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, FALL, LANDED, LOCK_REQ} state_t;

  localparam int unsigned SOFT_PERIOD = GRAV_PERIOD / SOFT_DIV;
  localparam logic [31:0] GRAV_TERM = (GRAV_PERIOD > 1) ? GRAV_PERIOD - 1 : 32'd0;
  localparam logic [31:0] SOFT_TERM = (SOFT_PERIOD > 1) ? SOFT_PERIOD - 1 : 32'd0;
  localparam logic [31:0] LOCK_TERM = (LOCK_PERIOD > 1) ? LOCK_PERIOD - 1 : 32'd0;
  localparam logic [`POS_LEN-1:0] ROW_STEP = `POS_LEN'(32);

  state_t              state, state_nxt;
  logic [`POS_LEN-1:0] pos_q, pos_nxt;
  logic [31:0]         grav_cnt, grav_nxt;
  logic [31:0]         lock_cnt, lock_nxt;
  logic [31:0]         grav_term;
  logic                grav_hit, lock_hit;
  // pend_q marks the cycle after a pos_set, when shift reflects the new position
  logic                pend_q, pend_nxt;
  logic [`POS_LEN-1:0] hd_pos;
`ifdef DROP_SCORE_EN
  logic [7:0]          drop_q, drop_nxt;

  function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [4:0] b);
    logic [8:0] sum;
    sum = {1'b0, a} + {4'b0, b};
    return sum[8] ? 8'hFF : sum[7:0];
  endfunction
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      pos_q    <= '0;
      grav_cnt <= '0;
      lock_cnt <= '0;
      pend_q   <= 1'b0;
`ifdef DROP_SCORE_EN
      drop_q   <= '0;
`endif
    end else begin
      state    <= state_nxt;
      pos_q    <= pos_nxt;
      grav_cnt <= grav_nxt;
      lock_cnt <= lock_nxt;
      pend_q   <= pend_nxt;
`ifdef DROP_SCORE_EN
      drop_q   <= drop_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt = state;
    pos_nxt   = pos_q;
    grav_nxt  = grav_cnt;
    lock_nxt  = lock_cnt;
    pend_nxt  = 1'b0;
`ifdef DROP_SCORE_EN
    drop_nxt  = drop_q;
`endif
    grav_term = bus.soft_drop ? SOFT_TERM : GRAV_TERM;
    grav_hit  = (grav_cnt >= grav_term);
    lock_hit  = (lock_cnt >= LOCK_TERM);
    hd_pos    = pos_q - `POS_LEN'({bus.shift[4:0], 5'b0});

    case (state)
      IDLE: begin
        if (bus.spawn) begin
          pos_nxt   = bus.pos_in;
          grav_nxt  = '0;
          state_nxt = FALL;
`ifdef DROP_SCORE_EN
          drop_nxt  = '0;
`endif
        end
      end
      FALL, LANDED: begin
        if (bus.hard_drop) begin
          pos_nxt   = hd_pos;
          state_nxt = LOCK_REQ;
`ifdef DROP_SCORE_EN
          drop_nxt  = sat_add(drop_q, bus.shift[4:0]);
`endif
        end else if (bus.pos_set) begin
          pos_nxt  = bus.pos_new;
          pend_nxt = 1'b1;
          // A coincident terminal count waits here so the step sees the new position's shift
          if (state == FALL && !grav_hit) grav_nxt = grav_cnt + 32'd1;
        end else if (state == FALL) begin
          if (!grav_hit) begin
            grav_nxt = grav_cnt + 32'd1;
          end else if (bus.shift != '0) begin
            pos_nxt  = pos_q - ROW_STEP;
            grav_nxt = '0;
`ifdef DROP_SCORE_EN
            if (bus.soft_drop) drop_nxt = sat_add(drop_q, 5'd1);
`endif
          end else begin
            state_nxt = LANDED;
            lock_nxt  = '0;
          end
        end else if (pend_q) begin
          if (bus.shift != '0) begin
            state_nxt = FALL;
            grav_nxt  = '0;
          end else begin
            lock_nxt  = '0;
          end
        end else if (lock_hit) begin
          state_nxt = LOCK_REQ;
        end else begin
          lock_nxt = lock_cnt + 32'd1;
        end
      end
      LOCK_REQ: begin
        if (bus.lock_ack) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.pos      = pos_q;
    bus.active   = (state == FALL) || (state == LANDED);
    bus.lock_req = (state == LOCK_REQ);
`ifdef DROP_SCORE_EN
    bus.drop_rows = drop_q;
`endif
  end

endmodule

// File: tb/tb_gravity_ctrl.sv
// Directed-vector bench for gravity_ctrl with GRAV_PERIOD=4, SOFT_DIV=2, LOCK_PERIOD=3.
module tb_gravity_ctrl;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  gravity_ctrl_if bus();

  gravity_ctrl #(
    .GRAV_PERIOD(4),
    .SOFT_DIV   (2),
    .LOCK_PERIOD(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b1;
    bus.spawn = 1'b0;     bus.pos_in = '0;
    bus.pos_set = 1'b0;   bus.pos_new = '0;
    bus.soft_drop = 1'b0; bus.hard_drop = 1'b0;
    bus.shift = '0;       bus.lock_ack = 1'b0;

    #3;
    check("rst_pos", 32'(bus.pos), 0);
    check("rst_active", 32'(bus.active), 0);
    check("rst_lock_req", 32'(bus.lock_req), 0);
`ifdef DROP_SCORE_EN
    check("rst_drop_rows", 32'(bus.drop_rows), 0);
`endif
    #9 rst = 1'b0;
    tick(1);

    // Normal gravity: spawn at row19/col4, shift 5
    bus.spawn = 1'b1; bus.pos_in = 10'd612; bus.shift = 20'd5;
    tick(1);
    bus.spawn = 1'b0;
    check("spawn_pos", 32'(bus.pos), 612);
    check("spawn_active", 32'(bus.active), 1);
    tick(3);
    check("grav_before_step", 32'(bus.pos), 612);
    tick(1);
    check("grav_step1", 32'(bus.pos), 580);
    tick(4);
    check("grav_step2", 32'(bus.pos), 548);

    // Landing then lock delay
    bus.shift = '0;
    tick(4);
    check("landed_pos", 32'(bus.pos), 548);
    check("landed_active", 32'(bus.active), 1);
    tick(2);
    check("lock_delay_wait", 32'(bus.lock_req), 0);
    tick(1);
    check("lock_req_set", 32'(bus.lock_req), 1);
    check("lock_active_low", 32'(bus.active), 0);
    bus.pos_set = 1'b1; bus.pos_new = 10'd100;
    tick(1);
    bus.pos_set = 1'b0;
    check("lock_pos_held", 32'(bus.pos), 548);
    bus.lock_ack = 1'b1; bus.spawn = 1'b1; bus.pos_in = 10'd200;
    tick(1);
    bus.lock_ack = 1'b0; bus.spawn = 1'b0;
    check("ack_lock_req", 32'(bus.lock_req), 0);
    check("ack_active", 32'(bus.active), 0);
    tick(1);
    check("spawn_dropped_active", 32'(bus.active), 0);
    check("spawn_dropped_pos", 32'(bus.pos), 548);

    // Hard drop with coincident pos_set
    bus.spawn = 1'b1; bus.pos_in = 10'd612; bus.shift = 20'd7;
    tick(1);
    bus.spawn = 1'b0;
    bus.hard_drop = 1'b1; bus.pos_set = 1'b1; bus.pos_new = 10'd613;
    tick(1);
    bus.hard_drop = 1'b0; bus.pos_set = 1'b0;
    check("hard_pos", 32'(bus.pos), 388);
    check("hard_lock_req", 32'(bus.lock_req), 1);
`ifdef DROP_SCORE_EN
    check("hard_drop_rows", 32'(bus.drop_rows), 7);
`endif
    bus.lock_ack = 1'b1;
    tick(1);
    bus.lock_ack = 1'b0;

    // Soft drop: step every 2 cycles
    bus.spawn = 1'b1; bus.pos_in = 10'd612; bus.shift = 20'd3; bus.soft_drop = 1'b1;
    tick(1);
    bus.spawn = 1'b0;
`ifdef DROP_SCORE_EN
    check("spawn_clears_drop_rows", 32'(bus.drop_rows), 0);
`endif
    tick(1);
    check("soft_before_step", 32'(bus.pos), 612);
    tick(1);
    check("soft_step1", 32'(bus.pos), 580);
    tick(2);
    check("soft_step2", 32'(bus.pos), 548);
`ifdef DROP_SCORE_EN
    check("soft_drop_rows", 32'(bus.drop_rows), 2);
`endif

    // Land under soft drop, then pos_set reopens space
    bus.shift = '0;
    tick(2);
    bus.soft_drop = 1'b0;
    check("soft_landed_pos", 32'(bus.pos), 548);
    bus.pos_set = 1'b1; bus.pos_new = 10'd613;
    tick(1);
    bus.pos_set = 1'b0; bus.shift = 20'd2;
    check("move_pos", 32'(bus.pos), 613);
    tick(1);
    check("refall_active", 32'(bus.active), 1);
    tick(3);
    check("refall_before_step", 32'(bus.pos), 613);
    tick(1);
    check("refall_step", 32'(bus.pos), 581);
    check("refall_no_lock", 32'(bus.lock_req), 0);

    // Hard drop ignores shift bits above [4:0]
    bus.shift = 20'h00021; bus.hard_drop = 1'b1;
    tick(1);
    bus.hard_drop = 1'b0;
    check("hard_low_bits_pos", 32'(bus.pos), 549);
    check("hard_low_bits_lock", 32'(bus.lock_req), 1);
`ifdef DROP_SCORE_EN
    check("hard_low_bits_drop_rows", 32'(bus.drop_rows), 3);
`endif

    // Asynchronous reset out of LOCK_REQ
    #2 rst = 1'b1;
    #1;
    check("async_rst_pos", 32'(bus.pos), 0);
    check("async_rst_lock_req", 32'(bus.lock_req), 0);
    check("async_rst_active", 32'(bus.active), 0);
    #1 rst = 1'b0;
    tick(2);
    check("post_rst_idle", 32'(bus.active), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
